// File: rtl/io_channel_hub_if.sv
// Core and environment side signal bundle for io_channel_hub.
// The hub takes the slave modport; the core/environment model takes master.
interface io_channel_hub_if #(
   parameter int D_WIDTH  = 34,
   parameter int PA_WIDTH = 4
);
   logic                core_in_req_i;
   logic [PA_WIDTH-1:0] core_in_addr_i;
   logic                core_in_ack_o;
   logic [D_WIDTH-1:0]  core_in_data_o;
   logic                core_out_req_i;
   logic [PA_WIDTH-1:0] core_out_addr_i;
   logic [D_WIDTH-1:0]  core_out_data_i;
   logic                core_out_ack_o;
   logic                ext_in_valid_i;
   logic [PA_WIDTH-1:0] ext_in_addr_i;
   logic [D_WIDTH-1:0]  ext_in_data_i;
   logic                ext_in_ready_o;
   logic                ext_out_valid_o;
   logic [PA_WIDTH-1:0] ext_out_addr_o;
   logic [D_WIDTH-1:0]  ext_out_data_o;
   logic                ext_out_ready_i;

   modport slave (
      input  core_in_req_i, core_in_addr_i,
      output core_in_ack_o, core_in_data_o,
      input  core_out_req_i, core_out_addr_i, core_out_data_i,
      output core_out_ack_o,
      input  ext_in_valid_i, ext_in_addr_i, ext_in_data_i,
      output ext_in_ready_o,
      output ext_out_valid_o, ext_out_addr_o, ext_out_data_o,
      input  ext_out_ready_i
   );

   modport master (
      output core_in_req_i, core_in_addr_i,
      input  core_in_ack_o, core_in_data_o,
      output core_out_req_i, core_out_addr_i, core_out_data_i,
      input  core_out_ack_o,
      output ext_in_valid_i, ext_in_addr_i, ext_in_data_i,
      input  ext_in_ready_o,
      input  ext_out_valid_o, ext_out_addr_o, ext_out_data_o,
      output ext_out_ready_i
   );
endinterface

// File: rtl/io_channel_hub.sv
// Terminates core I/O req/ack channels: per-address input FIFOs filled by the
// environment, and a single-entry output buffer drained with valid/ready.
module io_channel_hub #(
   parameter int D_WIDTH  = 34,
   parameter int PA_WIDTH = 4,
   parameter int DEPTH    = 4
) (
   input logic             clock,
   input logic             reset_i,
   io_channel_hub_if.slave bus
);
   localparam int NUM_CH = 2 ** PA_WIDTH;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH + 1);

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   state_t in_state_reg, in_state_next;
   state_t out_state_reg, out_state_next;

   logic [CW-1:0] count_vec  [NUM_CH];
   logic [PW-1:0] rd_ptr_vec [NUM_CH];
   logic [PW-1:0] wr_ptr_vec [NUM_CH];

   // All channel FIFOs share one array, indexed by {channel, pointer}.
   logic [D_WIDTH-1:0] mem_reg [NUM_CH*DEPTH];

   logic [PA_WIDTH+PW-1:0] wr_idx;
   logic [PA_WIDTH+PW-1:0] rd_idx;
   logic                   in_ready;
   logic                   push;
   logic                   pop;
   logic                   in_ack;
   logic [D_WIDTH-1:0]     in_data_reg;

   logic                   out_accept;
   logic                   out_ack;
   logic                   out_valid_reg;
   logic [PA_WIDTH-1:0]    out_addr_reg;
   logic [D_WIDTH-1:0]     out_data_reg;

   assign in_ready = (count_vec[bus.ext_in_addr_i] != CW'(DEPTH));
   assign push     = bus.ext_in_valid_i && in_ready;
   assign wr_idx   = {bus.ext_in_addr_i, wr_ptr_vec[bus.ext_in_addr_i]};
   assign rd_idx   = {bus.core_in_addr_i, rd_ptr_vec[bus.core_in_addr_i]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CW-1:0] count_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [PW-1:0] wr_ptr_reg;
         logic          ch_push;
         logic          ch_pop;

         assign ch_push = push && (bus.ext_in_addr_i == PA_WIDTH'(gi));
         assign ch_pop  = pop && (bus.core_in_addr_i == PA_WIDTH'(gi));

         // Pointers wrap naturally because DEPTH is a power of two.
         always_ff @(posedge clock) begin
            if (reset_i) begin
               count_reg  <= '0;
               rd_ptr_reg <= '0;
               wr_ptr_reg <= '0;
            end else begin
               if (ch_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
               if (ch_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
               if (ch_push && !ch_pop)      count_reg <= count_reg + CW'(1);
               else if (ch_pop && !ch_push) count_reg <= count_reg - CW'(1);
            end
         end

         assign count_vec[gi]  = count_reg;
         assign rd_ptr_vec[gi] = rd_ptr_reg;
         assign wr_ptr_vec[gi] = wr_ptr_reg;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (push) mem_reg[wr_idx] <= bus.ext_in_data_i;
   end

   // Registered read: the popped word lands here and holds until the next pop.
   always_ff @(posedge clock) begin
      if (reset_i)  in_data_reg <= '0;
      else if (pop) in_data_reg <= mem_reg[rd_idx];
   end

   always_ff @(posedge clock) begin
      if (reset_i) begin
         in_state_reg  <= ST_IDLE;
         out_state_reg <= ST_IDLE;
      end else begin
         in_state_reg  <= in_state_next;
         out_state_reg <= out_state_next;
      end
   end

   // Acks are masked while reset is asserted so an interrupted transfer never completes.
   always_comb begin
      in_state_next = in_state_reg;
      pop           = 1'b0;
      in_ack        = 1'b0;
      case (in_state_reg)
         ST_IDLE: begin
            if (bus.core_in_req_i && (count_vec[bus.core_in_addr_i] != '0)) begin
               pop           = 1'b1;
               in_state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            in_ack        = !reset_i;
            in_state_next = ST_IDLE;
         end
         default: in_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      out_state_next = out_state_reg;
      out_accept     = 1'b0;
      out_ack        = 1'b0;
      case (out_state_reg)
         ST_IDLE: begin
            if (bus.core_out_req_i && (!out_valid_reg || bus.ext_out_ready_i)) begin
               out_accept     = 1'b1;
               out_state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            out_ack        = !reset_i;
            out_state_next = ST_IDLE;
         end
         default: out_state_next = ST_IDLE;
      endcase
   end

   // A refill takes priority over a drain so valid stays high with no bubble.
   always_ff @(posedge clock) begin
      if (reset_i) begin
         out_valid_reg <= 1'b0;
         out_addr_reg  <= '0;
         out_data_reg  <= '0;
      end else if (out_accept) begin
         out_valid_reg <= 1'b1;
         out_addr_reg  <= bus.core_out_addr_i;
         out_data_reg  <= bus.core_out_data_i;
      end else if (out_valid_reg && bus.ext_out_ready_i) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.ext_in_ready_o  = in_ready;
   assign bus.core_in_ack_o   = in_ack;
   assign bus.core_in_data_o  = in_data_reg;
   assign bus.core_out_ack_o  = out_ack;
   assign bus.ext_out_valid_o = out_valid_reg;
   assign bus.ext_out_addr_o  = out_addr_reg;
   assign bus.ext_out_data_o  = out_data_reg;
endmodule

// File: tb/tb_io_channel_hub.sv
// Bench for io_channel_hub: behavioural FIFO/buffer model plus scoreboards
// for popped input words and drained output words.
module tb_io_channel_hub;
   localparam int D_WIDTH  = 34;
   localparam int PA_WIDTH = 4;
   localparam int DEPTH    = 4;
   localparam int NUM_CH   = 2 ** PA_WIDTH;

   logic clock = 1'b0;
   logic reset_i;
   always #5 clock = ~clock;

   io_channel_hub_if #(.D_WIDTH(D_WIDTH), .PA_WIDTH(PA_WIDTH)) bus ();

   io_channel_hub #(.D_WIDTH(D_WIDTH), .PA_WIDTH(PA_WIDTH), .DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset_i (reset_i),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_in_acks = 0;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference model state
   logic [D_WIDTH-1:0]          m_fifo [NUM_CH][$];
   logic [D_WIDTH-1:0]          exp_in_q [$];
   logic [PA_WIDTH+D_WIDTH-1:0] exp_out_q [$];
   bit                          m_in_ack, m_out_ack, m_out_valid, m_rdy, m_acc;
   logic [PA_WIDTH-1:0]         m_out_addr;
   logic [D_WIDTH-1:0]          m_out_data;
   bit                          mon_en = 1'b0;

   always @(posedge clock) begin
      if (reset_i) begin
         for (int c = 0; c < NUM_CH; c++) m_fifo[c].delete();
         exp_in_q.delete();
         m_in_ack    = 1'b0;
         m_out_ack   = 1'b0;
         m_out_valid = 1'b0;
         m_out_addr  = '0;
         m_out_data  = '0;
         mon_en      = 1'b1;
      end else begin
         m_rdy = (m_fifo[bus.ext_in_addr_i].size() != DEPTH);
         if (!m_in_ack && bus.core_in_req_i && m_fifo[bus.core_in_addr_i].size() != 0) begin
            exp_in_q.push_back(m_fifo[bus.core_in_addr_i].pop_front());
            m_in_ack = 1'b1;
         end else begin
            m_in_ack = 1'b0;
         end
         if (bus.ext_in_valid_i && m_rdy) m_fifo[bus.ext_in_addr_i].push_back(bus.ext_in_data_i);
         m_acc = !m_out_ack && bus.core_out_req_i && (!m_out_valid || bus.ext_out_ready_i);
         if (m_acc) begin
            m_out_valid = 1'b1;
            m_out_addr  = bus.core_out_addr_i;
            m_out_data  = bus.core_out_data_i;
         end else if (m_out_valid && bus.ext_out_ready_i) begin
            m_out_valid = 1'b0;
         end
         m_out_ack = m_acc;
      end
   end

   // Every cycle: compare DUT outputs to the model and retire scoreboard entries.
   always @(negedge clock) begin
      if (mon_en) begin
         check("in_ack", bus.core_in_ack_o, m_in_ack && !reset_i);
         if (bus.core_in_ack_o) begin
            n_in_acks++;
            if (exp_in_q.size() == 0) check("in_unexpected", 1, 0);
            else check("in_data", bus.core_in_data_o, exp_in_q.pop_front());
         end
         check("in_ready", bus.ext_in_ready_o, m_fifo[bus.ext_in_addr_i].size() != DEPTH);
         check("out_ack", bus.core_out_ack_o, m_out_ack && !reset_i);
         check("out_valid", bus.ext_out_valid_o, m_out_valid);
         if (m_out_valid) begin
            check("out_addr", bus.ext_out_addr_o, m_out_addr);
            check("out_data", bus.ext_out_data_o, m_out_data);
         end
         if (bus.ext_out_valid_o && bus.ext_out_ready_i && !reset_i) begin
            if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
            else check("out_word", {bus.ext_out_addr_o, bus.ext_out_data_o}, exp_out_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ack(input bit is_out, input int max, output int cycles);
      cycles = 0;
      for (int k = 0; k < max; k++) begin
         @(negedge clock);
         cycles++;
         if (is_out ? bus.core_out_ack_o : bus.core_in_ack_o) return;
      end
      if (is_out) check("out_ack_timeout", 0, 1);
      else check("in_ack_timeout", 0, 1);
   endtask

   task automatic push_word(input logic [PA_WIDTH-1:0] ch, input logic [D_WIDTH-1:0] d);
      bus.ext_in_valid_i = 1'b1;
      bus.ext_in_addr_i  = ch;
      bus.ext_in_data_i  = d;
      step();
      bus.ext_in_valid_i = 1'b0;
      $display("push ch%0d data 0x%0h", ch, d);
   endtask

   task automatic core_read(input logic [PA_WIDTH-1:0] ch, input logic [D_WIDTH-1:0] exp_d);
      int cyc;
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = ch;
      wait_ack(1'b0, 20, cyc);
      check("read_data", bus.core_in_data_o, exp_d);
      $display("read ch%0d data 0x%0h after %0d cycles", ch, bus.core_in_data_o, cyc);
      step();
      bus.core_in_req_i = 1'b0;
   endtask

   task automatic core_write_req(input logic [PA_WIDTH-1:0] port, input logic [D_WIDTH-1:0] d);
      bus.core_out_req_i  = 1'b1;
      bus.core_out_addr_i = port;
      bus.core_out_data_i = d;
      exp_out_q.push_back({port, d});
      $display("write req port %0d data 0x%0h", port, d);
   endtask

   initial begin
      int cyc;
      int acks_before;
      reset_i             = 1'b1;
      bus.core_in_req_i   = 1'b0;
      bus.core_in_addr_i  = '0;
      bus.core_out_req_i  = 1'b0;
      bus.core_out_addr_i = '0;
      bus.core_out_data_i = '0;
      bus.ext_in_valid_i  = 1'b0;
      bus.ext_in_addr_i   = '0;
      bus.ext_in_data_i   = '0;
      bus.ext_out_ready_i = 1'b0;
      step();
      step();
      reset_i = 1'b0;
      check("rst_in_data", bus.core_in_data_o, 0);
      check("rst_out_addr", bus.ext_out_addr_o, 0);
      check("rst_out_data", bus.ext_out_data_o, 0);

      // Single word round trip on ch3
      push_word(4'd3, 34'h1_2345_6789);
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = 4'd3;
      wait_ack(1'b0, 10, cyc);
      check("t1_latency", cyc, 2);
      check("t1_data", bus.core_in_data_o, 34'h1_2345_6789);
      step();
      bus.core_in_req_i = 1'b0;
      check("t1_single_pulse", bus.core_in_ack_o, 0);

      // Request held on empty ch5, then fill it
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = 4'd5;
      acks_before = n_in_acks;
      repeat (10) step();
      check("t2_no_ack_wait", n_in_acks - acks_before, 0);
      push_word(4'd5, 34'h2A);
      wait_ack(1'b0, 10, cyc);
      check("t2_latency", cyc, 2);
      check("t2_data", bus.core_in_data_o, 34'h2A);
      step();
      bus.core_in_req_i = 1'b0;

      // Fill ch0, stall a 5th push, pop to make room, then drain in order
      acks_before = n_in_acks;
      for (int i = 0; i < 4; i++) push_word(4'd0, 34'(32'h100 + i));
      bus.ext_in_valid_i = 1'b1;
      bus.ext_in_addr_i  = 4'd0;
      bus.ext_in_data_i  = 34'h104;
      check("t3_full_ready", bus.ext_in_ready_o, 0);
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = 4'd0;
      wait_ack(1'b0, 10, cyc);
      check("t3_ready_after_pop", bus.ext_in_ready_o, 1);
      check("t3_first", bus.core_in_data_o, 34'h100);
      step();
      bus.core_in_req_i  = 1'b0;
      bus.ext_in_valid_i = 1'b0;
      for (int i = 1; i < 5; i++) core_read(4'd0, 34'(32'h100 + i));
      check("t3_total_words", n_in_acks - acks_before, 5);

      // Same-cycle push and pop on ch1 holding two words
      push_word(4'd1, 34'h11);
      push_word(4'd1, 34'h22);
      bus.ext_in_valid_i = 1'b1;
      bus.ext_in_addr_i  = 4'd1;
      bus.ext_in_data_i  = 34'h33;
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = 4'd1;
      step();
      bus.ext_in_valid_i = 1'b0;
      @(negedge clock);
      check("t4_ack", bus.core_in_ack_o, 1);
      check("t4_oldest", bus.core_in_data_o, 34'h11);
      step();
      bus.core_in_req_i = 1'b0;
      core_read(4'd1, 34'h22);
      core_read(4'd1, 34'h33);
      acks_before = n_in_acks;
      bus.core_in_req_i = 1'b1;
      repeat (3) step();
      bus.core_in_req_i = 1'b0;
      check("t4_count_two", n_in_acks - acks_before, 0);

      // Output buffer back-pressure and zero-bubble refill
      core_write_req(4'd7, 34'hAA);
      wait_ack(1'b1, 10, cyc);
      check("t5_first_ack", cyc, 2);
      step();
      core_write_req(4'd7, 34'hBB);
      repeat (3) step();
      @(negedge clock);
      check("t5_withheld", bus.core_out_ack_o, 0);
      check("t5_hold_data", bus.ext_out_data_o, 34'hAA);
      step();
      bus.ext_out_ready_i = 1'b1;
      step();
      @(negedge clock);
      check("t5_refill_ack", bus.core_out_ack_o, 1);
      check("t5_valid_kept", bus.ext_out_valid_o, 1);
      check("t5_refill_data", bus.ext_out_data_o, 34'hBB);
      step();
      bus.core_out_req_i = 1'b0;
      step();
      bus.ext_out_ready_i = 1'b0;
      check("t5_drained", bus.ext_out_valid_o, 0);

      // Reset while the input FSM sits in ACK
      push_word(4'd2, 34'h77);
      push_word(4'd4, 34'h99);
      bus.core_in_req_i  = 1'b1;
      bus.core_in_addr_i = 4'd2;
      step();
      reset_i = 1'b1;
      @(negedge clock);
      check("t6_no_ack_in_reset", bus.core_in_ack_o, 0);
      step();
      reset_i = 1'b0;
      check("t6_in_data_zero", bus.core_in_data_o, 0);
      check("t6_out_valid_zero", bus.ext_out_valid_o, 0);
      check("t6_out_addr_zero", bus.ext_out_addr_o, 0);
      check("t6_out_data_zero", bus.ext_out_data_o, 0);
      acks_before = n_in_acks;
      repeat (4) step();
      bus.core_in_addr_i = 4'd4;
      repeat (4) step();
      bus.core_in_req_i = 1'b0;
      check("t6_fifos_empty", n_in_acks - acks_before, 0);
      step();

      check("in_scoreboard_empty", exp_in_q.size(), 0);
      check("out_scoreboard_empty", exp_out_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
